// File: rtl/pit_request_arbiter_pkg.sv
// Shared definitions for the PIT request arbiter:
// FSM states, result status codes and source ids.
package pit_request_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [2:0] STS_OK  = 3'b000;
    localparam logic [2:0] STS_DUP = 3'b010;
    localparam logic [2:0] STS_REJ = 3'b011;
    localparam logic [2:0] STS_TMO = 3'b100;

    localparam logic SRC_INT = 1'b0;
    localparam logic SRC_DAT = 1'b1;

endpackage

// File: rtl/pit_request_arbiter_slot.sv
// Single-entry request holding register.
// Ready is purely registered: no valid->ready path.
module pit_request_arbiter_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_free,
    output logic         o_ready,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // capture when empty, release on result handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_free) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/pit_request_arbiter.sv
// Round-robin arbiter between interest and data sources
// issuing one PIT lookup at a time with timeout.
module pit_request_arbiter
    import pit_request_arbiter_pkg::*;
#(
    parameter int PREFIX_W = 64,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                int_valid,
    input  logic [PREFIX_W-1:0] int_prefix,
    input  logic [5:0]          int_length,
    output logic                int_ready,
    input  logic                dat_valid,
    input  logic [PREFIX_W-1:0] dat_prefix,
    input  logic [7:0]          dat_meta,
    output logic                dat_ready,
    output logic [PREFIX_W-1:0] prefix,
    output logic [5:0]          length,
    output logic                out_bit,
    output logic [PREFIX_W-1:0] pit_out_prefix,
    output logic [7:0]          pit_out_metadata,
    output logic                prefix_ready,
    input  logic                pit_in_bit,
    input  logic                rejected,
    input  logic                data_packet,
    input  logic [10:0]         table_entry,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_src,
    output logic [2:0]          res_status,
    output logic [10:0]         res_entry
);

    localparam int INT_W = PREFIX_W + 6;
    localparam int DAT_W = PREFIX_W + 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t r_state;
    state_t w_next;

    logic                r_rr_last;
    logic                r_gnt;
    logic [PREFIX_W-1:0] r_prefix;
    logic [5:0]          r_length;
    logic                r_out_bit;
    logic [PREFIX_W-1:0] r_pit_out_prefix;
    logic [7:0]          r_pit_out_metadata;
    logic                r_prefix_ready;
    logic                r_prev_pib;
    logic                r_prev_rej;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_res_valid;
    logic                r_res_src;
    logic [2:0]          r_res_status;
    logic [10:0]         r_res_entry;

    logic             w_int_full;
    logic             w_dat_full;
    logic [INT_W-1:0] w_int_data;
    logic [DAT_W-1:0] w_dat_data;
    logic             w_any;
    logic             w_gnt;
    logic             w_pib_edge;
    logic             w_rej_edge;
    logic             w_tmo;
    logic             w_done;
    logic             w_hs;
    logic [2:0]       w_status;
    logic [10:0]      w_entry;

    assign w_hs = r_res_valid && res_ready;

    pit_request_arbiter_slot #(.W(INT_W)) u_int_slot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (int_valid),
        .i_data  ({int_prefix, int_length}),
        .i_free  (w_hs && (r_res_src == SRC_INT)),
        .o_ready (int_ready),
        .o_full  (w_int_full),
        .o_data  (w_int_data)
    );

    pit_request_arbiter_slot #(.W(DAT_W)) u_dat_slot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (dat_valid),
        .i_data  ({dat_prefix, dat_meta}),
        .i_free  (w_hs && (r_res_src == SRC_DAT)),
        .o_ready (dat_ready),
        .o_full  (w_dat_full),
        .o_data  (w_dat_data)
    );

    assign w_any      = w_int_full || w_dat_full;
    assign w_gnt      = (w_int_full && w_dat_full) ? !r_rr_last
                                                   : w_dat_full;
    assign w_pib_edge = pit_in_bit && !r_prev_pib;
    assign w_rej_edge = rejected && !r_prev_rej
                        && (r_gnt == SRC_DAT);
    assign w_tmo      = (r_cnt == CNT_LAST);
    assign w_done     = w_pib_edge || w_rej_edge || w_tmo;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // next state and response classification
    always_comb begin
        w_next   = r_state;
        w_status = STS_TMO;
        w_entry  = '0;
        unique case (r_state)
            ST_IDLE:  if (w_any)     w_next = ST_ISSUE;
            ST_ISSUE:                w_next = ST_WAIT;
            ST_WAIT:  if (w_done)    w_next = ST_RESP;
            ST_RESP:  if (res_ready) w_next = ST_IDLE;
        endcase
        if (w_pib_edge) begin
            w_status = data_packet ? STS_DUP : STS_OK;
            w_entry  = table_entry;
        end else if (w_rej_edge) begin
            w_status = STS_REJ;
        end
    end

    // PIT bus, request levels, timer and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last          <= SRC_DAT;
            r_gnt              <= SRC_INT;
            r_prefix           <= '0;
            r_length           <= '0;
            r_out_bit          <= 1'b0;
            r_pit_out_prefix   <= '0;
            r_pit_out_metadata <= '0;
            r_prefix_ready     <= 1'b0;
            r_prev_pib         <= 1'b0;
            r_prev_rej         <= 1'b0;
            r_cnt              <= '0;
            r_res_valid        <= 1'b0;
            r_res_src          <= 1'b0;
            r_res_status       <= '0;
            r_res_entry        <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt <= w_gnt;
                        if (w_gnt == SRC_DAT) begin
                            r_pit_out_prefix   <= w_dat_data[DAT_W-1:8];
                            r_pit_out_metadata <= w_dat_data[7:0];
                            r_prefix_ready     <= 1'b1;
                        end else begin
                            r_prefix  <= w_int_data[INT_W-1:6];
                            r_length  <= w_int_data[5:0];
                            r_out_bit <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_prev_pib <= pit_in_bit;
                    r_prev_rej <= rejected;
                    r_cnt      <= '0;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_out_bit      <= 1'b0;
                        r_prefix_ready <= 1'b0;
                        r_rr_last      <= r_gnt;
                        r_res_valid    <= 1'b1;
                        r_res_src      <= r_gnt;
                        r_res_status   <= w_status;
                        r_res_entry    <= w_entry;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (res_ready) r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign prefix           = r_prefix;
    assign length           = r_length;
    assign out_bit          = r_out_bit;
    assign pit_out_prefix   = r_pit_out_prefix;
    assign pit_out_metadata = r_pit_out_metadata;
    assign prefix_ready     = r_prefix_ready;
    assign res_valid        = r_res_valid;
    assign res_src          = r_res_src;
    assign res_status       = r_res_status;
    assign res_entry        = r_res_entry;

endmodule

// File: tb/tb_pit_request_arbiter.sv
// Directed and randomized checks of pit_request_arbiter
// against a transaction-level expectation model.
module tb_pit_request_arbiter;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        int_valid;
    logic [63:0] int_prefix;
    logic [5:0]  int_length;
    logic        int_ready;
    logic        dat_valid;
    logic [63:0] dat_prefix;
    logic [7:0]  dat_meta;
    logic        dat_ready;
    logic [63:0] prefix;
    logic [5:0]  length;
    logic        out_bit;
    logic [63:0] pit_out_prefix;
    logic [7:0]  pit_out_metadata;
    logic        prefix_ready;
    logic        pit_in_bit;
    logic        rejected;
    logic        data_packet;
    logic [10:0] table_entry;
    logic        res_valid;
    logic        res_ready;
    logic        res_src;
    logic [2:0]  res_status;
    logic [10:0] res_entry;

    int n_tests = 0;
    int n_fail  = 0;
    logic last_src = 1'b1;

    pit_request_arbiter #(
        .PREFIX_W (64),
        .TIMEOUT  (TMO),
        .CNT_W    (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .int_valid        (int_valid),
        .int_prefix       (int_prefix),
        .int_length       (int_length),
        .int_ready        (int_ready),
        .dat_valid        (dat_valid),
        .dat_prefix       (dat_prefix),
        .dat_meta         (dat_meta),
        .dat_ready        (dat_ready),
        .prefix           (prefix),
        .length           (length),
        .out_bit          (out_bit),
        .pit_out_prefix   (pit_out_prefix),
        .pit_out_metadata (pit_out_metadata),
        .prefix_ready     (prefix_ready),
        .pit_in_bit       (pit_in_bit),
        .rejected         (rejected),
        .data_packet      (data_packet),
        .table_entry      (table_entry),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_src          (res_src),
        .res_status       (res_status),
        .res_entry        (res_entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // one full transaction from one source; kind 0=silent 1=pit_in_bit 2=rejected
    task automatic run_txn(input logic src, input logic [63:0] pfx,
                           input logic [7:0] aux, input int kind,
                           input int d, input logic dp,
                           input logic [10:0] ent, input logic pre_rej,
                           input int hold);
        logic [1:0]  req;
        logic [2:0]  e_sts;
        logic [10:0] e_ent;
        int          e_idx;
        int          got;
        req = src ? 2'b01 : 2'b10;
        if (kind == 1 && d < TMO) begin
            e_idx = d;
            e_sts = dp ? 3'b010 : 3'b000;
            e_ent = ent;
        end else if (kind == 2 && src && d < TMO && !pre_rej) begin
            e_idx = d;
            e_sts = 3'b011;
            e_ent = '0;
        end else begin
            e_idx = TMO - 1;
            e_sts = 3'b100;
            e_ent = '0;
        end
        pit_in_bit  = 1'b0;
        rejected    = pre_rej;
        data_packet = dp;
        table_entry = '0;
        if (src) begin
            dat_valid  = 1'b1;
            dat_prefix = pfx;
            dat_meta   = aux;
        end else begin
            int_valid  = 1'b1;
            int_prefix = pfx;
            int_length = aux[5:0];
        end
        chk("ready_idle", src ? dat_ready : int_ready, 1);
        tick();
        int_valid = 1'b0;
        dat_valid = 1'b0;
        chk("ready_taken", src ? dat_ready : int_ready, 0);
        chk("req_cycle1", {out_bit, prefix_ready}, 0);
        tick();
        chk("req_cycle2", {out_bit, prefix_ready}, req);
        if (src)
            chk("bus_dat", {pit_out_prefix, pit_out_metadata},
                {pfx, aux});
        else
            chk("bus_int", {prefix, 2'b00, length},
                {pfx, 2'b00, aux[5:0]});
        tick();
        got = -1;
        for (int i = 0; i < TMO + 6; i++) begin
            if (res_valid) begin
                got = i - 1;
                break;
            end
            chk("req_hold", {out_bit, prefix_ready}, req);
            if (i == d && kind == 1) begin
                pit_in_bit  = 1'b1;
                table_entry = ent;
            end
            if (i == d && kind == 2) rejected = 1'b1;
            tick();
        end
        chk("resp_cycle", got, e_idx);
        pit_in_bit  = 1'b0;
        rejected    = 1'b0;
        table_entry = '0;
        chk("req_dropped", {out_bit, prefix_ready}, 0);
        chk("res", {res_valid, res_src, res_status, res_entry},
            {1'b1, src, e_sts, e_ent});
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            tick();
            chk("hold_res", {res_valid, res_src, res_status, res_entry},
                {1'b1, src, e_sts, e_ent});
            chk("hold_noreq", {out_bit, prefix_ready}, 0);
            chk("hold_ready", src ? dat_ready : int_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_done", res_valid, 0);
        chk("slot_freed", src ? dat_ready : int_ready, 1);
        last_src = src;
    endtask

    // wait for whichever request the arbiter grants and complete it
    task automatic serve(input logic exp_src, input int hold,
                         input logic other_pending);
        int   w;
        logic gs;
        w  = 0;
        gs = 1'b0;
        while (!(out_bit || prefix_ready) && w < 8) begin
            tick();
            w++;
        end
        chk("rr_req_seen", w < 8, 1);
        chk("rr_not_both", out_bit && prefix_ready, 0);
        gs = prefix_ready;
        chk("rr_grant", gs, exp_src);
        tick();
        pit_in_bit  = 1'b1;
        table_entry = 11'h0AA;
        data_packet = 1'b0;
        w = 0;
        while (!res_valid && w < 8) begin
            chk("rr_not_both", out_bit && prefix_ready, 0);
            tick();
            w++;
        end
        chk("rr_res_seen", w < 8, 1);
        pit_in_bit = 1'b0;
        chk("rr_res_src", res_src, exp_src);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rr_hold_res", {res_valid, res_src, res_status, res_entry},
                {1'b1, exp_src, 3'b000, 11'h0AA});
            chk("rr_hold_noreq", {out_bit, prefix_ready}, 0);
            chk("rr_hold_ready", exp_src ? dat_ready : int_ready, 0);
            if (other_pending)
                chk("rr_hold_other", exp_src ? int_ready : dat_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        last_src = exp_src;
    endtask

    initial begin
        logic [1:0] pend;
        logic       nxt;
        rst = 1'b1;
        int_valid = 0; int_prefix = '0; int_length = '0;
        dat_valid = 0; dat_prefix = '0; dat_meta = '0;
        pit_in_bit = 0; rejected = 0; data_packet = 0;
        table_entry = '0; res_ready = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", {int_ready, dat_ready}, 2'b11);
        chk("rst_req", {out_bit, prefix_ready}, 0);
        chk("rst_bus", {prefix, length, pit_out_prefix, pit_out_metadata}, 0);
        chk("rst_res", {res_valid, res_src, res_status, res_entry}, 0);

        run_txn(1'b0, 64'hA5, 8'd8, 1, 1, 1'b0, 11'h005, 1'b0, 0);
        run_txn(1'b1, 64'hA5, 8'h48, 1, 0, 1'b1, 11'h405, 1'b0, 0);
        run_txn(1'b1, 64'h1234, 8'h40, 2, 2, 1'b0, 11'h3FF, 1'b0, 0);
        run_txn(1'b1, 64'h5678, 8'h40, 0, 0, 1'b0, 11'h000, 1'b1, 0);
        run_txn(1'b0, 64'h99, 8'd3, 2, 1, 1'b0, 11'h7FF, 1'b0, 0);
        run_txn(1'b0, 64'h77, 8'd5, 1, TMO - 1, 1'b1, 11'h123, 1'b0, 2);
        run_txn(1'b1, 64'h66, 8'h01, 1, TMO, 1'b0, 11'h321, 1'b0, 0);

        for (int r = 0; r < 16; r++) begin
            run_txn(1'($urandom_range(0, 1)),
                    {$urandom, $urandom},
                    8'($urandom),
                    int'($urandom_range(0, 2)),
                    int'($urandom_range(0, TMO + 1)),
                    1'($urandom_range(0, 1)),
                    11'($urandom),
                    1'b0,
                    int'($urandom_range(0, 3)));
        end

        pend = 2'b11;
        int_valid = 1'b1; int_prefix = 64'h10; int_length = 6'd1;
        dat_valid = 1'b1; dat_prefix = 64'h20; dat_meta = 8'h40;
        tick();
        int_valid = 1'b0;
        dat_valid = 1'b0;
        for (int rd = 0; rd < 4; rd++) begin
            if (rd == 2) begin
                pend = 2'b11;
                int_valid = 1'b1;
                dat_valid = 1'b1;
                tick();
                int_valid = 1'b0;
                dat_valid = 1'b0;
            end
            nxt = (pend == 2'b11) ? !last_src : pend[1];
            serve(nxt, (rd == 0) ? 10 : 0, pend == 2'b11);
            pend[nxt] = 1'b0;
        end

        dat_valid = 1'b1; dat_prefix = 64'hBEEF; dat_meta = 8'h40;
        tick();
        dat_valid = 1'b0;
        tick();
        tick();
        int_valid = 1'b1;
        tick();
        int_valid = 1'b0;
        chk("wait_req", prefix_ready, 1);
        chk("wait_int_full", int_ready, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_req", {out_bit, prefix_ready}, 0);
        chk("mid_rst_ready", {int_ready, dat_ready}, 2'b11);
        chk("mid_rst_res", res_valid, 0);
        rst = 1'b0;
        last_src = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle", {out_bit, prefix_ready, res_valid}, 0);
        end
        run_txn(1'b0, 64'hC0DE, 8'd9, 1, 0, 1'b0, 11'h00F, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
